// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: state codes and their width.
package pll_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous level, cleared to 0 on reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock stability,
// releases the system reset, re-sequences on loss/timeout/request and parks
// in a sticky failure state after too many lock timeouts.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 100,
  parameter int unsigned LOCK_STABLE_CYC  = 5000,
  parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned CNT_W            = 20
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   pll_locked_i,
  input  logic                   relock_req_i,
  output logic                   pll_rst_o,
  output logic                   sys_reset_n_o,
  output logic                   fail_o,
  output logic [SEQ_STATE_W-1:0] seq_state_o,
  output logic [1:0]             retry_cnt_o,
  output logic [7:0]             lock_lost_cnt_o
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  logic             lock_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  logic             pll_rst_q;
  logic             sys_reset_n_q;
  logic             fail_q;

  sync_2ff u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .d_i     (pll_locked_i),
    .q_o     (lock_s)
  );

  // Sequencing decisions; software requests win over lock events except in RUN.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (relock_req_i) begin
          state_d = ST_PLL_RST;
        end else if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        if (relock_req_i) begin
          state_d = ST_PLL_RST;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = 2'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
          state_d = ST_PLL_RST;
        end else if (relock_req_i) begin
          state_d = ST_PLL_RST;
        end
      end
      ST_FAIL: begin
        if (relock_req_i) begin
          state_d = ST_PLL_RST;
          retry_d = 2'd0;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase
  end

  // Shared cycle counter: restarts on every state change, idle in RUN and FAIL.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_d != state_q) || (state_q == ST_RUN) || (state_q == ST_FAIL)) begin
      cnt_d = '0;
    end
  end

  // Sequencer state, counter and event counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      retry_q <= 2'd0;
      lost_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
    end
  end

  // Registered outputs; system reset releases one cycle into RUN and drops on exit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      pll_rst_q     <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      sys_reset_n_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
      fail_q        <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign sys_reset_n_o   = sys_reset_n_q;
  assign fail_o          = fail_q;
  assign seq_state_o     = state_q;
  assign retry_cnt_o     = retry_q;
  assign lock_lost_cnt_o = lost_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock sequencer for the fluid-board SoC clock PLL (50 MHz and 12 MHz outputs). Runs on the free-running 50 MHz reference clock and drives the PLL reset. It qualifies the PLL lock indication for stability before releasing the downstream system reset. On lock loss, lock timeout or software request it re-sequences, and after a bounded number of failed attempts it parks in a sticky FAIL state.

## Interface
Parameters:
- RST_PULSE_CYC, 100 — `pll_rst` high time, in `clk` cycles (2 µs).
- LOCK_STABLE_CYC, 5000 — consecutive synchronized-lock-high cycles required before release (100 µs).
- LOCK_TIMEOUT_CYC, 500000 — maximum wait for lock after `pll_rst` drops (10 ms).
- MAX_RETRIES, 3 — lock timeouts tolerated before FAIL.
- CNT_W, 20 — shared cycle-counter width; must hold max(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC).

Ports:
- clk  in  1  50 MHz free-running reference; never a PLL output.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  raw PLL lock, asynchronous to `clk`.
- relock_req  in  1  single-cycle software re-sequence request.
- pll_rst  out  1  PLL reset, active high.
- sys_reset_n  out  1  downstream reset, active low, registered.
- fail  out  1  sticky failure flag.
- seq_state  out  3  current state code.
- retry_cnt  out  2  timeouts since last RUN.
- lock_lost_cnt  out  8  lock losses seen in RUN, saturating at 255.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to produce `lock_s`; all decisions use `lock_s` only.
- State codes: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLL_RST:
  - `pll_rst`=1.
  - Counter runs 0..RST_PULSE_CYC-1, then the FSM goes to WAIT_LOCK with the counter cleared.
  - `relock_req` is ignored.
- WAIT_LOCK:
  - `lock_s`=1 → STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT_CYC-1 with `lock_s` still 0:
    - retry_cnt==MAX_RETRIES → FAIL.
    - otherwise retry_cnt+1 → PLL_RST.
  - `relock_req` → PLL_RST; retry_cnt unchanged.
- STABLE:
  - `lock_s`=0 → WAIT_LOCK with the counter cleared; the timeout window restarts.
  - Counter reaches LOCK_STABLE_CYC-1 with `lock_s`=1 → RUN; retry_cnt cleared.
  - `relock_req` → PLL_RST.
- RUN:
  - `sys_reset_n`=1.
  - `lock_s`=0 → lock_lost_cnt+1 (saturating) → PLL_RST.
  - `relock_req` → PLL_RST; not counted as a loss.
  - Both events in the same cycle: counted as a lock loss.
- FAIL:
  - `fail`=1, `pll_rst`=1.
  - `relock_req` → PLL_RST; clears retry_cnt and `fail`.
- `sys_reset_n`:
  - Register, driven 1 only in the cycle after the FSM is in RUN.
  - Cleared in the same edge that leaves RUN.
- `pll_rst` is 1 in PLL_RST and FAIL, 0 elsewhere.
- The counter is a single CNT_W-bit up-counter, cleared on every state transition.

## Timing
- Reset values:
  - state=PLL_RST, counter=0.
  - `pll_rst`=1, `sys_reset_n`=0, `fail`=0.
  - retry_cnt=0, lock_lost_cnt=0, synchronizer flops=0.
- Reset is asynchronous, mid-sequence included. All state returns to the reset values immediately; the release is synchronous to `clk`.
- `pll_rst` pulse: exactly RST_PULSE_CYC cycles per PLL_RST entry.
- Input latency: `pll_locked` edge to `lock_s` is 2–3 cycles.
- Lock rise at the pin to `sys_reset_n`=1: at most 3 + LOCK_STABLE_CYC + 1 cycles.
- Lock loss at the pin while in RUN to `sys_reset_n`=0: at most 3 cycles (2 sync + 1 register).
- A `lock_s` glitch shorter than LOCK_STABLE_CYC in STABLE never releases reset.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum with the fixed codes above;
  - the SEQ_STATE_W=3 constant.
- Sub-module `sync_2ff`: 1-bit, 2-stage synchronizer with async active-low clear to 0. Reused for `pll_locked`.
- All remaining logic (FSM, counter, outputs) lives in a single always block per concern.

## Test plan
Test parameters: RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=50, MAX_RETRIES=2.
- Clean start: release `reset_n`, raise `pll_locked` 10 cycles after `pll_rst` falls.
  - Required: `pll_rst` high exactly 4 cycles.
  - Required: `sys_reset_n` rises at most 12 cycles after the lock edge.
  - Required: seq_state goes 0→1→2→3.
- Lock glitch in STABLE: drop `pll_locked` for 2 cycles, 5 cycles into STABLE.
  - Required: returns to WAIT_LOCK, re-qualifies for a full 8 cycles, `sys_reset_n` stays 0 throughout.
- Lock loss in RUN: drop `pll_locked`.
  - Required: `sys_reset_n`=0 within 3 cycles, lock_lost_cnt=1, a new 4-cycle `pll_rst` pulse.
- Timeouts: keep `pll_locked`=0.
  - Required: 3 pulses of `pll_rst`, with retry_cnt going 0→1→2.
  - Required: on the third timeout, seq_state=4, `fail`=1, `pll_rst` held high.
  - Then pulse `relock_req`: required `fail`=0, retry_cnt=0, seq_state=0.
- Simultaneous `relock_req` and lock drop in RUN: required lock_lost_cnt increments by exactly 1.
  - Then `relock_req` alone in RUN: lock_lost_cnt unchanged.
- Reset mid-WAIT_LOCK with retry_cnt=1: assert `reset_n` for 1 cycle.
  - Required: all outputs at their reset values asynchronously.
  - Required: the sequence restarts with a full 4-cycle pulse.
